// File: rtl/clock_mode_controller_pkg.sv
// clock_pkg: shared types and constants for the clock mode controller.
//   mode_t       : controller state / displayed mode (RUN, SET_HRS, SET_MIN)
//   *_MAX        : largest legal digit values of the time fields
//   *_MODULO     : field moduli derived from those limits (60, 60, 24)
package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HRS = 2'd1,
      SET_MIN = 2'd2
   } mode_t;

   localparam int SEC_TENS_MAX      = 5;
   localparam int MIN_TENS_MAX      = 5;
   localparam int HRS_MAX_TENS      = 2;
   localparam int HRS_MAX_UNIT_AT_2 = 3;

   localparam int SEC_MODULO = (SEC_TENS_MAX + 1) * 10;
   localparam int MIN_MODULO = (MIN_TENS_MAX + 1) * 10;
   localparam int HRS_MODULO = HRS_MAX_TENS * 10 + HRS_MAX_UNIT_AT_2 + 1;

endpackage

// File: rtl/clock_mode_controller_if.sv
// clock_mode_if: button/tick pulses into the controller and the digit and
// blink outputs towards the display driver.
//   master : drives tick_1hz, mode_p, inc_p; observes the display fields
//   slave  : the controller; consumes pulses, drives digits, mode, blanks
interface clock_mode_if;
   logic       tick_1hz;
   logic       mode_p;
   logic       inc_p;
   logic [3:0] sec_unit;
   logic [2:0] sec_tens;
   logic [3:0] min_unit;
   logic [2:0] min_tens;
   logic [3:0] hrs_unit;
   logic [1:0] hrs_tens;
   logic [1:0] mode;
   logic       blank_hrs;
   logic       blank_min;

   modport master (
      output tick_1hz, mode_p, inc_p,
      input  sec_unit, sec_tens, min_unit, min_tens, hrs_unit, hrs_tens,
             mode, blank_hrs, blank_min
   );

   modport slave (
      input  tick_1hz, mode_p, inc_p,
      output sec_unit, sec_tens, min_unit, min_tens, hrs_unit, hrs_tens,
             mode, blank_hrs, blank_min
   );
endinterface

// File: rtl/clock_mode_controller_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MODULO-1 -> 00.
//   clk, rst_n : clock, synchronous active-low reset
//   i_inc      : advance by one
//   i_clr      : clear to 00 (takes priority over i_inc)
//   o_unit     : units digit (registered)
//   o_tens     : tens digit (registered)
//   o_carry    : i_inc while at the wrap value (combinational, for chaining)
module bcd_mod_counter #(
   parameter int MODULO = 60,
   parameter int TENS_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_inc,
   input  logic              i_clr,
   output logic [3:0]        o_unit,
   output logic [TENS_W-1:0] o_tens,
   output logic              o_carry
);

   localparam logic [3:0]        MAX_UNIT = 4'((MODULO - 1) % 10);
   localparam logic [TENS_W-1:0] MAX_TENS = TENS_W'((MODULO - 1) / 10);

   logic [3:0]        r_unit;
   logic [TENS_W-1:0] r_tens;
   logic              w_at_max;

   assign w_at_max = (r_unit == MAX_UNIT) && (r_tens == MAX_TENS);
   assign o_carry  = i_inc & w_at_max;
   assign o_unit   = r_unit;
   assign o_tens   = r_tens;

   // Digit registers: clear, wrap at the modulo, or ripple units into tens.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_unit <= 4'd0;
         r_tens <= '0;
      end else if (i_clr) begin
         r_unit <= 4'd0;
         r_tens <= '0;
      end else if (i_inc) begin
         if (w_at_max) begin
            r_unit <= 4'd0;
            r_tens <= '0;
         end else if (r_unit == 4'd9) begin
            r_unit <= 4'd0;
            r_tens <= r_tens + TENS_W'(1);
         end else begin
            r_unit <= r_unit + 4'd1;
         end
      end
   end

endmodule

// File: rtl/clock_mode_controller.sv
// clock_mode_controller: RUN / SET_HRS / SET_MIN sequencer and HH:MM:SS core.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : clock_mode_if.slave - tick/mode/inc pulses in; BCD digits,
//                mode and hour/minute blink masks out (all registered)
module clock_mode_controller
   import clock_pkg::*;
#(
   parameter int MODE_TIMEOUT = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   clock_mode_if.slave  bus
);

   mode_t      r_state, w_state_nxt;
   logic [3:0] r_tmo, w_tmo_nxt;
   logic       r_phase, w_phase_nxt;
   logic       r_blank_hrs, r_blank_min;
   logic       w_sec_inc, w_sec_clr, w_min_inc, w_hrs_inc;
   logic       w_sec_carry, w_min_carry;

   // State, inactivity counter, blink phase and registered blink masks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_tmo       <= 4'd0;
         r_phase     <= 1'b0;
         r_blank_hrs <= 1'b0;
         r_blank_min <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tmo       <= w_tmo_nxt;
         r_phase     <= w_phase_nxt;
         r_blank_hrs <= w_phase_nxt & (w_state_nxt == SET_HRS);
         r_blank_min <= w_phase_nxt & (w_state_nxt == SET_MIN);
      end
   end

   // Next state and field-update strobes; mode_p has priority over inc_p,
   // and any button press overrides a simultaneous timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_tmo_nxt   = r_tmo;
      w_phase_nxt = r_phase;
      w_sec_inc   = 1'b0;
      w_sec_clr   = 1'b0;
      w_min_inc   = 1'b0;
      w_hrs_inc   = 1'b0;
      case (r_state)
         RUN: begin
            w_sec_inc = bus.tick_1hz;
            w_min_inc = w_sec_carry;
            w_hrs_inc = w_min_carry;
            if (bus.mode_p) begin
               w_state_nxt = SET_HRS;
               w_tmo_nxt   = 4'd0;
               w_phase_nxt = 1'b0;
            end else begin
               w_state_nxt = RUN;
            end
         end
         SET_HRS, SET_MIN: begin
            if (bus.mode_p) begin
               w_state_nxt = (r_state == SET_HRS) ? SET_MIN : RUN;
               w_sec_clr   = (r_state == SET_MIN);
               w_tmo_nxt   = 4'd0;
               w_phase_nxt = 1'b0;
            end else begin
               if (bus.tick_1hz) begin
                  w_phase_nxt = ~r_phase;
               end else begin
                  w_phase_nxt = r_phase;
               end
               if (bus.inc_p) begin
                  // Minutes wrap without carrying: hours strobe stays low here.
                  w_hrs_inc = (r_state == SET_HRS);
                  w_min_inc = (r_state == SET_MIN);
                  w_tmo_nxt = 4'd0;
               end else if (bus.tick_1hz) begin
                  if (r_tmo == 4'(MODE_TIMEOUT - 1)) begin
                     w_state_nxt = RUN;
                     w_sec_clr   = 1'b1;
                     w_tmo_nxt   = 4'd0;
                     w_phase_nxt = 1'b0;
                  end else begin
                     w_tmo_nxt = r_tmo + 4'd1;
                  end
               end else begin
                  w_tmo_nxt = r_tmo;
               end
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_tmo_nxt   = 4'd0;
            w_phase_nxt = 1'b0;
         end
      endcase
   end

   bcd_mod_counter #(.MODULO(SEC_MODULO), .TENS_W(3)) u_sec (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_sec_inc),
      .i_clr   (w_sec_clr),
      .o_unit  (bus.sec_unit),
      .o_tens  (bus.sec_tens),
      .o_carry (w_sec_carry)
   );

   bcd_mod_counter #(.MODULO(MIN_MODULO), .TENS_W(3)) u_min (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_min_inc),
      .i_clr   (1'b0),
      .o_unit  (bus.min_unit),
      .o_tens  (bus.min_tens),
      .o_carry (w_min_carry)
   );

   // Day rollover needs no further chaining, so the hours carry is left open.
   bcd_mod_counter #(.MODULO(HRS_MODULO), .TENS_W(2)) u_hrs (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_hrs_inc),
      .i_clr   (1'b0),
      .o_unit  (bus.hrs_unit),
      .o_tens  (bus.hrs_tens),
      .o_carry ()
   );

   assign bus.mode      = r_state;
   assign bus.blank_hrs = r_blank_hrs;
   assign bus.blank_min = r_blank_min;

endmodule
